// File: rtl/fetch_flow_ctrl_pkg.sv
// Shared fetch-side constants and types.
// Contents: FSM state encoding, default bubble (NOP) instruction encoding and
// the PC increment. The hazard unit and decode import this package for the
// same NOP encoding.
package fetch_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL    = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_REDIRECT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam int          PC_INC        = 4;

endpackage

// File: rtl/fetch_flow_ctrl_if.sv
// Fetch flow-control bundle between the hazard unit / fetch memory (master)
// and fetch_flow_ctrl (slave).
// master drives: PC_Write, IF_ID_Write, NOP, BrTaken_MEM, BrTarget_MEM, Instr_IF
// slave drives : PC, Instr_ID, PC_ID, Valid_ID, Kill_EX, State, Stall_Cnt,
//                Bubble_Cnt
interface fetch_flow_ctrl_if #(
   parameter int PC_W = 32
);
   logic            PC_Write;
   logic            IF_ID_Write;
   logic            NOP;
   logic            BrTaken_MEM;
   logic [PC_W-1:0] BrTarget_MEM;
   logic [PC_W-1:0] Instr_IF;
   logic [PC_W-1:0] PC;
   logic [PC_W-1:0] Instr_ID;
   logic [PC_W-1:0] PC_ID;
   logic            Valid_ID;
   logic            Kill_EX;
   logic [1:0]      State;
   logic [15:0]     Stall_Cnt;
   logic [15:0]     Bubble_Cnt;

   modport master (
      output PC_Write, IF_ID_Write, NOP, BrTaken_MEM, BrTarget_MEM, Instr_IF,
      input  PC, Instr_ID, PC_ID, Valid_ID, Kill_EX, State, Stall_Cnt, Bubble_Cnt
   );

   modport slave (
      input  PC_Write, IF_ID_Write, NOP, BrTaken_MEM, BrTarget_MEM, Instr_IF,
      output PC, Instr_ID, PC_ID, Valid_ID, Kill_EX, State, Stall_Cnt, Bubble_Cnt
   );
endinterface

// File: rtl/fetch_flow_ctrl_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
// Ports: clk_sys, rst_b (async, active-low), inc (count enable), cnt (value).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/fetch_flow_ctrl.sv
// fetch_flow_ctrl: owns the PC, the IF/ID register and the ID/EX bubble kill.
// Applies hazard-unit PC_Write / IF_ID_Write / NOP each cycle, redirects fetch
// on a taken branch from MEM, and counts stall and bubble cycles.
// Ports: CLK, RST_N (async, active-low), bus (fetch_flow_ctrl_if.slave).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal fetch, PC and IF/ID both advancing
// STALL    | PC and IF/ID frozen by the hazard unit
// DRAIN    | PC advanced but IF/ID held; fetched word dropped
// REDIRECT | taken branch loaded target PC, IF/ID holds a bubble
module fetch_flow_ctrl
   import fetch_flow_ctrl_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] NOP_INSTR = PC_W'(NOP_INSTR_DEF)
) (
   input  logic               CLK,
   input  logic               RST_N,
   fetch_flow_ctrl_if.slave   bus
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] instr_id_q;
   logic [PC_W-1:0] pc_id_q;
   logic            valid_id_q;
   fetch_state_e    state_q;
   fetch_state_e    state_d;
   logic            kill_ex;
   logic            stall_inc;

   // Branch redirect overrides any stall request from the hazard unit.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q       <= RESET_PC;
         instr_id_q <= NOP_INSTR;
         pc_id_q    <= '0;
         valid_id_q <= 1'b0;
      end else begin
         if (bus.BrTaken_MEM) begin
            pc_q <= bus.BrTarget_MEM;
         end else if (bus.PC_Write) begin
            pc_q <= pc_q + PC_W'(PC_INC);
         end

         if (bus.BrTaken_MEM) begin
            instr_id_q <= NOP_INSTR;
            pc_id_q    <= '0;
            valid_id_q <= 1'b0;
         end else if (bus.IF_ID_Write) begin
            instr_id_q <= bus.Instr_IF;
            pc_id_q    <= pc_q;
            valid_id_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // PC_Write=0 with IF_ID_Write=1 is not a legal hazard-unit request; it
   // lands in RUN since the datapath simply reloads IF/ID from the held PC.
   always_comb begin
      state_d = ST_RUN;
      if (bus.BrTaken_MEM) begin
         state_d = ST_REDIRECT;
      end else if (!bus.PC_Write && !bus.IF_ID_Write) begin
         state_d = ST_STALL;
      end else if (bus.PC_Write && !bus.IF_ID_Write) begin
         state_d = ST_DRAIN;
      end
   end

   assign kill_ex   = bus.NOP | ~valid_id_q;
   assign stall_inc = ~bus.PC_Write & ~bus.BrTaken_MEM;

   sat_counter #(.W(16)) u_stall_cnt (
      .clk_sys (CLK),
      .rst_b   (RST_N),
      .inc     (stall_inc),
      .cnt     (bus.Stall_Cnt)
   );

   sat_counter #(.W(16)) u_bubble_cnt (
      .clk_sys (CLK),
      .rst_b   (RST_N),
      .inc     (kill_ex),
      .cnt     (bus.Bubble_Cnt)
   );

   assign bus.PC       = pc_q;
   assign bus.Instr_ID = instr_id_q;
   assign bus.PC_ID    = pc_id_q;
   assign bus.Valid_ID = valid_id_q;
   assign bus.Kill_EX  = kill_ex;
   assign bus.State    = state_q;

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Directed bench for fetch_flow_ctrl. Instruction memory returns
// {16'hC0DE, PC[15:0]} so IF/ID contents are traceable to the fetch address.
module tb_fetch_flow_ctrl;

   logic CLK;
   logic RST_N;
   int   n_vec;
   int   n_miss;

   fetch_flow_ctrl_if #(.PC_W(32)) bus ();

   fetch_flow_ctrl #(
      .PC_W      (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always_comb bus.Instr_IF = {16'hC0DE, bus.PC[15:0]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pc_id, input logic valid,
                          input logic kill, input logic [1:0] st,
                          input logic [15:0] stall, input logic [15:0] bubble);
      chk({tag, ".pc"},     bus.PC,         pc);
      chk({tag, ".instr"},  bus.Instr_ID,   instr);
      chk({tag, ".pc_id"},  bus.PC_ID,      pc_id);
      chk({tag, ".valid"},  32'(bus.Valid_ID),   32'(valid));
      chk({tag, ".kill"},   32'(bus.Kill_EX),    32'(kill));
      chk({tag, ".state"},  32'(bus.State),      32'(st));
      chk({tag, ".stall"},  32'(bus.Stall_Cnt),  32'(stall));
      chk({tag, ".bubble"}, 32'(bus.Bubble_Cnt), 32'(bubble));
   endtask

   task automatic drive(input logic pcw, input logic ifw, input logic nop,
                        input logic br, input logic [31:0] tgt);
      bus.PC_Write     = pcw;
      bus.IF_ID_Write  = ifw;
      bus.NOP          = nop;
      bus.BrTaken_MEM  = br;
      bus.BrTarget_MEM = tgt;
   endtask

   // one rising edge, then settle away from it
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      RST_N  = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #3;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 16'd0, 16'd0);

      @(posedge CLK);
      #2;
      RST_N = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

      // first edge after reset sees Kill_EX=1 (Valid_ID=0), so one bubble counts
      step();
      chk_all("run1", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 1'b0, 2'd0, 16'd0, 16'd1);
      step();
      chk_all("run2", 32'h8, 32'hC0DE_0004, 32'h4, 1'b1, 1'b0, 2'd0, 16'd0, 16'd1);

      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      chk("stall.kill_comb", 32'(bus.Kill_EX), 32'd1);
      step();
      chk_all("stall", 32'h8, 32'hC0DE_0004, 32'h4, 1'b1, 1'b1, 2'd1, 16'd1, 16'd2);

      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
      #1;
      chk("branch.kill_comb", 32'(bus.Kill_EX), 32'd0);
      step();
      chk_all("branch", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 2'd3, 16'd1, 16'd2);

      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      chk_all("drain", 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 2'd2, 16'd1, 16'd3);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk_all("resume", 32'h48, 32'hC0DE_0044, 32'h44, 1'b1, 1'b0, 2'd0, 16'd1, 16'd4);

      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk_all("illegal", 32'h48, 32'hC0DE_0048, 32'h48, 1'b1, 1'b0, 2'd0, 16'd2, 16'd4);

      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      chk_all("preset", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 2'd3, 16'd2, 16'd4);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk_all("wrap", 32'h0, 32'hC0DE_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 2'd0, 16'd2, 16'd5);

      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (65532) step();
      chk("sat.below", 32'(bus.Stall_Cnt), 32'h0000_FFFE);
      step();
      chk("sat.reach", 32'(bus.Stall_Cnt), 32'h0000_FFFF);
      repeat (7) step();
      chk_all("sat.hold", 32'h0, 32'hC0DE_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 2'd1, 16'hFFFF, 16'd5);

      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
      step();
      chk("redir.pc", bus.PC, 32'h80);
      chk("redir.state", 32'(bus.State), 32'd3);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      RST_N = 1'b0;
      #1;
      chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd0, 16'd0, 16'd0);
      step();
      chk("rst_held.pc", bus.PC, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
